// File: rtl/psram_xfer_arb_pkg.sv
// Shared encodings and default widths for the PSRAM transfer arbiter.
package psram_xfer_arb_pkg;

  localparam int unsigned PSRAM_ADDR_W      = 32;
  localparam int unsigned PSRAM_DATA_W      = 64;
  localparam int unsigned PSRAM_TIMEOUT_CYC = 1024;

  localparam logic PSRAM_ARB_CFG = 1'b0;
  localparam logic PSRAM_ARB_BUS = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StBusy  = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/psram_arb_rr.sv
// Two-way round-robin picker: on a tie the requester other than rr_i wins.
module psram_arb_rr
  import psram_xfer_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       rr_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  always_comb begin
    gnt_idx_o = PSRAM_ARB_CFG;
    if (req_i == 2'b11) begin
      gnt_idx_o = ~rr_i;
    end else if (req_i[PSRAM_ARB_BUS]) begin
      gnt_idx_o = PSRAM_ARB_BUS;
    end
    gnt_o = (|req_i) ? idx_to_onehot(gnt_idx_o) : 2'b00;
  end

endmodule

// File: rtl/psram_xfer_arb.sv
// CFG/BUS arbiter and sequencer for the psram_core transfer port.
// Optional watchdog enabled by defining PSRAM_ARB_TIMEOUT_EN.
module psram_xfer_arb
  import psram_xfer_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = PSRAM_ADDR_W,
  parameter int unsigned DATA_W      = PSRAM_DATA_W,
  parameter int unsigned TIMEOUT_CYC = PSRAM_TIMEOUT_CYC
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cfg_req_i,
  input  logic                cfg_rdwr_i,
  input  logic [ADDR_W-1:0]   cfg_addr_i,
  input  logic [DATA_W-1:0]   cfg_wdata_i,
  input  logic [DATA_W/8-1:0] cfg_wmask_i,
  output logic                cfg_ack_o,
  output logic [DATA_W-1:0]   cfg_rdata_o,
  input  logic                bus_req_i,
  input  logic                bus_rdwr_i,
  input  logic [ADDR_W-1:0]   bus_addr_i,
  input  logic [DATA_W-1:0]   bus_wdata_i,
  input  logic [DATA_W/8-1:0] bus_wmask_i,
  output logic                bus_ack_o,
  output logic [DATA_W-1:0]   bus_rdata_o,
  output logic                xfer_valid_o,
  output logic                xfer_rdwr_o,
  output logic                xfer_cfg_o,
  output logic [ADDR_W-1:0]   xfer_addr_o,
  output logic [DATA_W-1:0]   xfer_wdata_o,
  output logic [DATA_W/8-1:0] xfer_wmask_o,
  input  logic                xfer_ready_i,
  input  logic [DATA_W-1:0]   xfer_rdata_i,
  output logic                busy_o,
  output logic                err_o
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  arb_state_e          state_q, state_d;
  logic                rr_q;
  logic                xfer_cfg_q, xfer_rdwr_q;
  logic [ADDR_W-1:0]   xfer_addr_q;
  logic [DATA_W-1:0]   xfer_wdata_q;
  logic [DATA_W/8-1:0] xfer_wmask_q;
  logic [DATA_W-1:0]   cfg_rdata_q, bus_rdata_q;
  logic [1:0]          gnt;
  logic                gnt_idx;
  logic                grant, capture, timeout;
  logic                win_idx;

  assign win_idx = xfer_cfg_q ? PSRAM_ARB_CFG : PSRAM_ARB_BUS;

  psram_arb_rr u_rr (
    .req_i     ({bus_req_i, cfg_req_i}),
    .rr_i      (rr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

`ifdef PSRAM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
      if (grant) begin
        cnt_q <= '0;
      end else if (state_q == StIssue || state_q == StBusy) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign timeout = (state_q == StIssue || state_q == StBusy) && (cnt_q == CntMax);
  assign err_o   = (state_q == StDone) && err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (xfer_ready_i && |gnt) begin
          grant   = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (timeout) begin
          state_d = StDone;
        end else if (!xfer_ready_i) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (timeout) begin
          state_d = StDone;
        end else if (xfer_ready_i) begin
          capture = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= StIdle;
      rr_q         <= PSRAM_ARB_BUS;
      xfer_cfg_q   <= 1'b0;
      xfer_rdwr_q  <= 1'b0;
      xfer_addr_q  <= '0;
      xfer_wdata_q <= '0;
      xfer_wmask_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDone) begin
        rr_q <= win_idx;
      end
      if (grant) begin
        xfer_cfg_q   <= (gnt_idx == PSRAM_ARB_CFG);
        xfer_rdwr_q  <= gnt_idx ? bus_rdwr_i  : cfg_rdwr_i;
        xfer_addr_q  <= gnt_idx ? bus_addr_i  : cfg_addr_i;
        xfer_wdata_q <= gnt_idx ? bus_wdata_i : cfg_wdata_i;
        xfer_wmask_q <= gnt_idx ? bus_wmask_i : cfg_wmask_i;
      end
    end
  end

  // A timed-out transfer reports zero data even for writes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cfg_rdata_q <= '0;
      bus_rdata_q <= '0;
    end else if (timeout || (capture && xfer_rdwr_q)) begin
      if (win_idx == PSRAM_ARB_CFG) begin
        cfg_rdata_q <= timeout ? '0 : xfer_rdata_i;
      end else begin
        bus_rdata_q <= timeout ? '0 : xfer_rdata_i;
      end
    end
  end

  assign xfer_valid_o = (state_q == StIssue);
  assign busy_o       = (state_q != StIdle);
  assign cfg_ack_o    = (state_q == StDone) && (win_idx == PSRAM_ARB_CFG);
  assign bus_ack_o    = (state_q == StDone) && (win_idx == PSRAM_ARB_BUS);
  assign xfer_rdwr_o  = xfer_rdwr_q;
  assign xfer_cfg_o   = xfer_cfg_q;
  assign xfer_addr_o  = xfer_addr_q;
  assign xfer_wdata_o = xfer_wdata_q;
  assign xfer_wmask_o = xfer_wmask_q;
  assign cfg_rdata_o  = cfg_rdata_q;
  assign bus_rdata_o  = bus_rdata_q;

endmodule

// File: tb/tb_psram_xfer_arb.sv
// Directed bench for psram_xfer_arb with a transaction-level reference model.
module tb_psram_xfer_arb;

  localparam int unsigned To = 16;
`ifdef PSRAM_ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_req = 1'b0, cfg_rdwr = 1'b0, bus_req = 1'b0, bus_rdwr = 1'b0;
  logic [31:0] cfg_addr = '0, bus_addr = '0;
  logic [63:0] cfg_wdata = '0, bus_wdata = '0;
  logic [7:0]  cfg_wmask = '0, bus_wmask = '0;
  logic        cfg_ack_o, bus_ack_o;
  logic [63:0] cfg_rdata_o, bus_rdata_o;
  logic        xfer_valid_o, xfer_rdwr_o, xfer_cfg_o;
  logic [31:0] xfer_addr_o;
  logic [63:0] xfer_wdata_o;
  logic [7:0]  xfer_wmask_o;
  logic        xfer_ready_i = 1'b1;
  logic [63:0] xfer_rdata_i = '0;
  logic        busy_o, err_o;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;

  always #5 clk_i = ~clk_i;

  psram_xfer_arb #(
    .ADDR_W      (32),
    .DATA_W      (64),
    .TIMEOUT_CYC (To)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n),
    .cfg_req_i    (cfg_req),
    .cfg_rdwr_i   (cfg_rdwr),
    .cfg_addr_i   (cfg_addr),
    .cfg_wdata_i  (cfg_wdata),
    .cfg_wmask_i  (cfg_wmask),
    .cfg_ack_o    (cfg_ack_o),
    .cfg_rdata_o  (cfg_rdata_o),
    .bus_req_i    (bus_req),
    .bus_rdwr_i   (bus_rdwr),
    .bus_addr_i   (bus_addr),
    .bus_wdata_i  (bus_wdata),
    .bus_wmask_i  (bus_wmask),
    .bus_ack_o    (bus_ack_o),
    .bus_rdata_o  (bus_rdata_o),
    .xfer_valid_o (xfer_valid_o),
    .xfer_rdwr_o  (xfer_rdwr_o),
    .xfer_cfg_o   (xfer_cfg_o),
    .xfer_addr_o  (xfer_addr_o),
    .xfer_wdata_o (xfer_wdata_o),
    .xfer_wmask_o (xfer_wmask_o),
    .xfer_ready_i (xfer_ready_i),
    .xfer_rdata_i (xfer_rdata_i),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Reference model: one transfer in flight, tracked as "granted / core went busy / acking".
  logic        m_act, m_low, m_ack, m_err, m_who, m_last, m_rdwr;
  int          m_age;
  logic [31:0] m_addr;
  logic [63:0] m_wdata, m_rd0, m_rd1;
  logic [7:0]  m_wmask;

  function automatic logic pick(input logic c, input logic b, input logic last);
    if (c && b) return !last;
    return !c;
  endfunction

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0; m_low <= 1'b0; m_ack <= 1'b0; m_err <= 1'b0;
      m_who <= 1'b1; m_last <= 1'b1; m_rdwr <= 1'b0; m_age <= 0;
      m_addr <= '0; m_wdata <= '0; m_wmask <= '0; m_rd0 <= '0; m_rd1 <= '0;
    end else if (m_ack) begin
      m_ack  <= 1'b0;
      m_err  <= 1'b0;
      m_last <= m_who;
    end else if (!m_act) begin
      if (xfer_ready_i && (cfg_req || bus_req)) begin
        m_act   <= 1'b1;
        m_low   <= 1'b0;
        m_age   <= 0;
        m_who   <= pick(cfg_req, bus_req, m_last);
        m_rdwr  <= pick(cfg_req, bus_req, m_last) ? bus_rdwr  : cfg_rdwr;
        m_addr  <= pick(cfg_req, bus_req, m_last) ? bus_addr  : cfg_addr;
        m_wdata <= pick(cfg_req, bus_req, m_last) ? bus_wdata : cfg_wdata;
        m_wmask <= pick(cfg_req, bus_req, m_last) ? bus_wmask : cfg_wmask;
      end
    end else begin
      m_age <= m_age + 1;
      if (ToEn && m_age == To - 1) begin
        m_act <= 1'b0;
        m_ack <= 1'b1;
        m_err <= 1'b1;
        if (m_who) m_rd1 <= '0;
        else       m_rd0 <= '0;
      end else if (!m_low) begin
        if (!xfer_ready_i) m_low <= 1'b1;
      end else if (xfer_ready_i) begin
        m_act <= 1'b0;
        m_ack <= 1'b1;
        if (m_rdwr) begin
          if (m_who) m_rd1 <= xfer_rdata_i;
          else       m_rd0 <= xfer_rdata_i;
        end
      end
    end
  end

  always @(negedge clk_i) begin
    chk1("valid", xfer_valid_o, m_act && !m_low);
    chk1("busy", busy_o, m_act || m_ack);
    chk1("cfg_ack", cfg_ack_o, m_ack && !m_who);
    chk1("bus_ack", bus_ack_o, m_ack && m_who);
    chk1("err", err_o, m_ack && m_err);
    chk1("xfer_cfg", xfer_cfg_o, !m_who);
    chk1("xfer_rdwr", xfer_rdwr_o, m_rdwr);
    chkw("xfer_addr", 64'(xfer_addr_o), 64'(m_addr));
    chkw("xfer_wdata", xfer_wdata_o, m_wdata);
    chkw("xfer_wmask", 64'(xfer_wmask_o), 64'(m_wmask));
    chkw("cfg_rdata", cfg_rdata_o, m_rd0);
    chkw("bus_rdata", bus_rdata_o, m_rd1);
    if (xfer_valid_o) vcnt = vcnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required completion");
    $fatal(1);
  end

  // Core emulation: go busy in the first cycle valid is seen, stay busy lo cycles.
  task automatic serve(input string name, input int lo, input logic [63:0] rd);
    int n;
    n = 0;
    while (!xfer_valid_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!xfer_valid_o) begin
      total++;
      bad++;
      $display("FAIL %s: no xfer_valid_o within 50 cycles (required one)", name);
    end
    xfer_ready_i = 1'b0;
    repeat (lo) @(negedge clk_i);
    xfer_rdata_i = rd;
    xfer_ready_i = 1'b1;
  endtask

  task automatic wait_ack(input string name, output int who);
    who = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (cfg_ack_o) begin who = 0; break; end
      if (bus_ack_o) begin who = 1; break; end
    end
    if (who < 0) begin
      total++;
      bad++;
      $display("FAIL %s: no ack within 100 cycles (required one)", name);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n = 1'b1;
  endtask

  initial begin
    int who;
    int n;
    int order [4];
    int exp_order [4];
    bit acked;
    exp_order = '{0, 1, 0, 1};

    // Reset state.
    @(negedge clk_i);
    chk1("rst_valid", xfer_valid_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_acks", cfg_ack_o | bus_ack_o, 1'b0);
    chkw("rst_rdata", cfg_rdata_o | bus_rdata_o, 64'h0);
    rst_n = 1'b1;

    // 1: single CFG write.
    @(negedge clk_i);
    cfg_req = 1'b1; cfg_rdwr = 1'b0; cfg_addr = 32'h0000_0010;
    cfg_wdata = 64'hA5; cfg_wmask = 8'h01;
    vcnt = 0;
    serve("t1", 6, 64'hDEAD_BEEF);
    wait_ack("t1", who);
    chki("t1_winner", who, 0);
    chk1("t1_xfer_cfg", xfer_cfg_o, 1'b1);
    chk1("t1_bus_ack", bus_ack_o, 1'b0);
    cfg_req = 1'b0;
    @(negedge clk_i);
    chk1("t1_ack_pulse", cfg_ack_o, 1'b0);
    chki("t1_valid_cycles", vcnt, 1);

    // 2: BUS read; request and fields change after grant.
    bus_req = 1'b1; bus_rdwr = 1'b1; bus_addr = 32'h0000_0100;
    serve("t2", 3, 64'h0123_4567_89AB_CDEF);
    bus_req = 1'b0; bus_addr = 32'hFFFF_FFFF; bus_rdwr = 1'b0;
    wait_ack("t2", who);
    chki("t2_winner", who, 1);
    chkw("t2_rdata", bus_rdata_o, 64'h0123_4567_89AB_CDEF);
    chk1("t2_xfer_cfg", xfer_cfg_o, 1'b0);
    chk1("t2_xfer_rdwr", xfer_rdwr_o, 1'b1);
    chkw("t2_xfer_addr", 64'(xfer_addr_o), 64'h100);
    bus_addr = 32'h0000_0300; bus_rdwr = 1'b1;

    // 3: both requesting from reset, four transfers.
    do_reset();
    cfg_req = 1'b1; cfg_rdwr = 1'b1; cfg_addr = 32'h0000_0200;
    bus_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve("t3", 2, 64'h1111_0000 + 64'(i));
      wait_ack("t3", who);
      order[i] = who;
    end
    cfg_req = 1'b0; bus_req = 1'b0;
    for (int i = 0; i < 4; i++) chki("t3_order", order[i], exp_order[i]);

    // 4: core not idle when the request arrives.
    @(negedge clk_i);
    xfer_ready_i = 1'b0;
    cfg_req = 1'b1; cfg_rdwr = 1'b0; cfg_addr = 32'h0000_0040;
    repeat (4) begin
      @(negedge clk_i);
      chk1("t4_no_valid", xfer_valid_o, 1'b0);
      chk1("t4_no_busy", busy_o, 1'b0);
    end
    xfer_ready_i = 1'b1;
    @(negedge clk_i);
    chk1("t4_grant_after_ready", xfer_valid_o, 1'b1);
    serve("t4", 1, 64'h0);
    wait_ack("t4", who);
    chki("t4_winner", who, 0);
    cfg_req = 1'b0;

    // 5: asynchronous reset while the core is busy.
    @(negedge clk_i);
    bus_req = 1'b1; bus_rdwr = 1'b1; bus_addr = 32'h0000_0500;
    n = 0;
    while (!xfer_valid_o && n < 20) begin @(negedge clk_i); n++; end
    xfer_ready_i = 1'b0;
    @(negedge clk_i);
    chk1("t5_in_busy", busy_o, 1'b1);
    #2 rst_n = 1'b0;
    bus_req = 1'b0;
    #1;
    chk1("t5_rst_valid", xfer_valid_o, 1'b0);
    chk1("t5_rst_busy", busy_o, 1'b0);
    chk1("t5_rst_ack", bus_ack_o | cfg_ack_o, 1'b0);
    chkw("t5_rst_addr", 64'(xfer_addr_o), 64'h0);
    chkw("t5_rst_rdata", bus_rdata_o, 64'h0);
    @(negedge clk_i);
    rst_n = 1'b1;
    xfer_rdata_i = 64'h5555_5555_5555_5555;
    xfer_ready_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk1("t5_no_ack", bus_ack_o | cfg_ack_o, 1'b0);
    end
    cfg_req = 1'b1; cfg_rdwr = 1'b1; cfg_addr = 32'h0000_0600;
    serve("t5", 3, 64'hCAFE_F00D_1234_5678);
    wait_ack("t5", who);
    chki("t5_winner", who, 0);
    chkw("t5_rdata", cfg_rdata_o, 64'hCAFE_F00D_1234_5678);
    cfg_req = 1'b0;

    // 6: core never goes busy.
    @(negedge clk_i);
    cfg_req = 1'b1; cfg_rdwr = 1'b0; cfg_addr = 32'h0000_0700;
    n = 0;
    while (!xfer_valid_o && n < 20) begin @(negedge clk_i); n++; end
    chk1("t6_valid", xfer_valid_o, 1'b1);
    n = 0;
    acked = 1'b0;
    while (!acked && n < 100) begin
      @(negedge clk_i);
      n++;
      acked = cfg_ack_o;
    end
`ifdef PSRAM_ARB_TIMEOUT_EN
    chki("t6_timeout_cycles", n, 16);
    chk1("t6_err", err_o, 1'b1);
    chkw("t6_rdata_zero", cfg_rdata_o, 64'h0);
`else
    chk1("t6_no_ack", acked, 1'b0);
    chk1("t6_still_valid", xfer_valid_o, 1'b1);
`endif
    cfg_req = 1'b0;
    do_reset();
    repeat (2) @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
